pipe_mem_arbiter: RTL and testbench

Shares one single-port memory between the pipeline's instruction-fetch port and its load/store port. It is built for the unified-memory build of the 5-stage pipeline. Requests are arbitrated with data-first priority plus an anti-starvation bound for fetch. Each access runs through a req/gnt/rvalid memory handshake, and a stall output tells the pipeline to freeze PC/IR until its accesses complete.

---
 rtl/pipe_mem_pkg.sv | 16 +
 rtl/pipe_mem_arbiter.sv | 113 +++++++++++
 tb/tb_pipe_mem_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the pipeline's unified-memory arbiter.
package pipe_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int DEF_MAX_DSTREAK = 4;

endpackage

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// data first with a bounded number of consecutive data grants while fetch waits.
//
// state | meaning
// IDLE  | arbitrate between if_req and d_req
// ISSUE | mem_req high, mem_* held until mem_gnt
// WAIT  | waiting for mem_rvalid, read data captured on arrival
// RESP  | owner's valid pulses; no arbitration this cycle
module pipe_mem_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    state_t        state;
    logic          owner;
    logic [SW-1:0] streak;
    logic          fetch_starved;

    assign fetch_starved = if_req && (streak == STREAK_MAX);
    assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req && !fetch_starved) begin
                        owner     <= OWN_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= ISSUE;
                        // Only count data wins that actually made fetch wait.
                        if (!if_req)
                            streak <= '0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + SW'(1);
                    end else if (if_req) begin
                        owner    <= OWN_I;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        streak   <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (owner == OWN_D) begin
                            d_valid <= 1'b1;
                            if (!mem_we)
                                d_rdata <= mem_rdata;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: vector table, corner-case sequences
// and randomized traffic against a transaction-level reference model.
module tb_pipe_mem_arbiter;
    import pipe_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata;
    logic        if_valid, d_valid, stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_mem_arbiter #(.AW(32), .DW(32), .MAX_DSTREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
    endtask

    // ---------------- memory responder ----------------
    bit          resp_en = 1'b0;
    bit          use_arr = 1'b0;
    int          fix_gd = 0, fix_rd = 0;
    int          gd_arr[256];
    int          rd_arr[256];
    int          tx_k = 0;
    logic [31:0] mem_arr[64];
    logic        r_gnt = 1'b0, r_rvalid = 1'b0;
    logic [31:0] r_rdata = 32'h0BAD_0BAD;
    logic        m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    assign mem_gnt    = resp_en ? r_gnt    : m_gnt;
    assign mem_rvalid = resp_en ? r_rvalid : m_rvalid;
    assign mem_rdata  = resp_en ? r_rdata  : m_rdata;

    initial begin
        int phase, g_cnt, r_cnt;
        logic [31:0] rd_val;
        phase = 0; g_cnt = 0; r_cnt = 0; rd_val = '0;
        forever begin
            @(negedge clk);
            r_gnt = 1'b0;
            r_rvalid = 1'b0;
            r_rdata = 32'h0BAD_0BAD;
            if (!resp_en || rst) begin
                phase = 0;
                if (rst) tx_k = 0;
            end else if (phase == 2) begin
                if (r_cnt == 0) begin
                    r_rvalid = 1'b1;
                    r_rdata = rd_val;
                    phase = 0;
                end else r_cnt--;
            end else begin
                if (phase == 0 && mem_req) begin
                    g_cnt = use_arr ? gd_arr[tx_k % 256] : fix_gd;
                    r_cnt = use_arr ? rd_arr[tx_k % 256] : fix_rd;
                    tx_k++;
                    phase = 1;
                end
                if (phase == 1) begin
                    if (g_cnt == 0) begin
                        r_gnt = 1'b1;
                        if (mem_we) begin
                            mem_arr[mem_addr[7:2]] = mem_wdata;
                            rd_val = 32'hFFFF_FFFF;
                        end else rd_val = mem_arr[mem_addr[7:2]];
                        phase = 2;
                    end else g_cnt--;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    logic [31:0] mm[64];

    function automatic logic [31:0] pattern(input int i);
        return (i == 16) ? 32'h2008_0005 : (32'hA5A5_0000 | 32'(i));
    endfunction

    task automatic init_mem();
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = pattern(i);
            mm[i] = pattern(i);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gd;
        int          rd;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int t;
        bit seen, done;
        fix_gd = v.gd;
        fix_rd = v.rd;
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        t = cyc;
        #1 chk({tag, "_stall_req"}, 32'(stall), 32'd1);
        seen = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (mem_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    chk({tag, "_issue_cycle"}, 32'(cyc - t), 32'd1);
                    chk({tag, "_mem_we"}, 32'(mem_we), 32'(v.we));
                end
                chk({tag, "_mem_addr"}, mem_addr, v.addr);
                if (v.we) chk({tag, "_mem_wdata"}, mem_wdata, v.wdata);
            end
            if (cyc - t < v.exp_lat) chk({tag, "_stall_busy"}, 32'(stall), 32'd1);
            if (v.is_d ? d_valid : if_valid) begin
                done = 1'b1;
                chk({tag, "_latency"}, 32'(cyc - t), 32'(v.exp_lat));
                chk({tag, "_rdata"}, v.is_d ? d_rdata : if_rdata, v.exp_rdata);
                chk({tag, "_stall_resp"}, 32'(stall), 32'd0);
                if (v.is_d) d_req = 1'b0; else if_req = 1'b0;
            end
        end
        if (!done) timeout({tag, "_valid"});
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    // ---------------- main sequence ----------------
    vec_t vecs[6];
    int   exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        int t, tv, got;
        bit prev_req, found;
        int order[10];

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        init_mem();

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        if_req = 1'b1; if_addr = 32'h40; m_gnt = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_mem_req", 32'(mem_req), 32'd0);
        end
        if_req = 1'b0; m_gnt = 1'b0;
        rst = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);

        // vector table
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'h2008_0005, 3};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 3, 2, 32'hA5A5_0020, 8};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 1, 0, 32'hA5A5_0020, 4};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, 1, 32'hCAFE_F00D, 4};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_00FC, 32'h0, 2, 2, 32'hA5A5_003F, 7};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'h2008_0005, 3};
        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        chk("if_rdata_held", if_rdata, 32'hA5A5_003F);

        // simultaneous fetch and store: store first, then fetch in next IDLE
        do_reset();
        fix_gd = 0; fix_rd = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (mem_req) begin
                found = 1'b1;
                chk("sim_first_we", 32'(mem_we), 32'd1);
                chk("sim_first_addr", mem_addr, 32'h100);
                chk("sim_first_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
        end
        if (!found) timeout("sim_first_issue");
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (d_valid) begin
                found = 1'b1;
                chk("sim_store_d_rdata", d_rdata, 32'h0);
                chk("sim_store_no_ifv", 32'(if_valid), 32'd0);
                d_req = 1'b0; d_we = 1'b0;
            end
        end
        if (!found) timeout("sim_store_valid");
        tv = cyc;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (mem_req) begin
                found = 1'b1;
                chk("sim_fetch_issue_cycle", 32'(cyc - tv), 32'd2);
                chk("sim_fetch_addr", mem_addr, 32'h44);
                chk("sim_fetch_we", 32'(mem_we), 32'd0);
            end
        end
        if (!found) timeout("sim_fetch_issue");
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (if_valid) begin
                found = 1'b1;
                chk("sim_fetch_valid_cycle", 32'(cyc - tv), 32'd4);
                chk("sim_fetch_rdata", if_rdata, 32'hA5A5_0011);
                if_req = 1'b0;
            end
        end
        if (!found) timeout("sim_fetch_valid");

        // starvation bound with both ports permanently requesting
        do_reset();
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
        got = 0;
        prev_req = 1'b0;
        for (int k = 0; k < 100 && got < 10; k++) begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                order[got] = int'(mem_addr[12]);
                got++;
            end
            prev_req = mem_req;
        end
        if (got < 10) timeout("starve_grants");
        for (int i = 0; i < got; i++)
            chk($sformatf("starve_grant%0d", i), 32'(order[i]), 32'(exp_order[i]));

        // reset while in WAIT; the late rvalid must be ignored
        resp_en = 1'b0;
        do_reset();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (mem_req) found = 1'b1;
        end
        if (!found) timeout("mid_rst_issue");
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        chk("mid_rst_wait_mem_req", 32'(mem_req), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d_req = 1'b0;
        m_rvalid = 1'b1;
        m_rdata = 32'h1234_5678;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        m_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_d_valid", 32'(d_valid), 32'd0);
            chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
            chk("mid_rst_d_rdata", d_rdata, 32'd0);
            chk("mid_rst_mem_req_idle", 32'(mem_req), 32'd0);
        end
        resp_en = 1'b1;
        begin
            vec_t v;
            v = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'h2008_0005, 3};
            run_vec(v, "post_rst_fetch");
        end

        // randomized traffic against a transaction-level model
        begin
            bit          m_busy, m_own, m_we, exp_iv, exp_dv;
            int          m_done, m_k, m_streak, n;
            logic [31:0] m_val, m_ifr, m_dr;
            init_mem();
            for (int i = 0; i < 256; i++) begin
                gd_arr[i] = $urandom_range(0, 3);
                rd_arr[i] = $urandom_range(0, 3);
            end
            use_arr = 1'b1;
            do_reset();
            m_busy = 1'b0; m_own = 1'b0; m_we = 1'b0;
            m_done = 0; m_k = 0; m_streak = 0;
            m_val = '0; m_ifr = '0; m_dr = '0;
            for (int i = 0; i < 1500; i++) begin
                @(negedge clk);
                n = cyc;
                exp_iv = m_busy && (m_done == n) && !m_own;
                exp_dv = m_busy && (m_done == n) && m_own;
                if (exp_iv) m_ifr = m_val;
                if (exp_dv && !m_we) m_dr = m_val;
                chk("rnd_if_valid", 32'(if_valid), 32'(exp_iv));
                chk("rnd_d_valid", 32'(d_valid), 32'(exp_dv));
                chk("rnd_if_rdata", if_rdata, m_ifr);
                chk("rnd_d_rdata", d_rdata, m_dr);

                if (if_req) begin
                    if (if_valid) begin
                        if_req = 1'($urandom_range(0, 1));
                        if_addr = rand_addr();
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    if_req = 1'b1;
                    if_addr = rand_addr();
                end
                if (d_req) begin
                    if (d_valid) begin
                        d_req = 1'($urandom_range(0, 1));
                        d_we = 1'($urandom_range(0, 1));
                        d_addr = rand_addr();
                        d_wdata = $urandom;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    d_req = 1'b1;
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = rand_addr();
                    d_wdata = $urandom;
                end
                #1 chk("rnd_stall", 32'(stall), 32'((if_req & ~exp_iv) | (d_req & ~exp_dv)));

                if (m_busy && n > m_done) m_busy = 1'b0;
                if (!m_busy && (if_req || d_req)) begin
                    if (d_req && !(if_req && m_streak == 4)) begin
                        m_own = 1'b1;
                        m_we = d_we;
                        if (d_we) mm[d_addr[7:2]] = d_wdata;
                        else m_val = mm[d_addr[7:2]];
                        m_streak = if_req ? ((m_streak < 4) ? m_streak + 1 : 4) : 0;
                    end else begin
                        m_own = 1'b0;
                        m_we = 1'b0;
                        m_val = mm[if_addr[7:2]];
                        m_streak = 0;
                    end
                    m_done = n + 3 + gd_arr[m_k % 256] + rd_arr[m_k % 256];
                    m_k++;
                    m_busy = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
